tia_hsync_counter: RTL and testbench
====================================

# tia_hsync_counter

Horizontal sync counter for the TIA. A 6-bit polynomial (LFSR) counter advances once every four color clocks, making a 228-clock scan line. It decodes fixed counter states into one-clock set/reset strobes, which drive the horizontal blank, sync and colour-burst latches downstream. It also holds the two level outputs that its strobes control directly: `hblank` and `hsync`.

## Interface
- Parameters: none; period (57 states) and divide ratio (4) are fixed.
- `clk`  in  1  color clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rsync`  in  1  RSYNC strobe, one clk wide; restarts the line
- `hmove_stb`  in  1  HMOVE strobe, one clk wide; requests extended blank on the current line
- `lfsr`  out  6  current counter state
- `phase`  out  2  color-clock phase within the current state, 0..3
- `shb`  out  1  set-HBLANK strobe (line start)
- `shs`  out  1  set-HSYNC strobe
- `rhs`  out  1  reset-HSYNC strobe
- `rcb`  out  1  reset-colour-burst strobe
- `rhb`  out  1  reset-HBLANK strobe (normal)
- `lrhb`  out  1  late reset-HBLANK strobe (HMOVE line)
- `cnt`  out  1  centre-of-line strobe
- `hblank`  out  1  horizontal blank level
- `hsync`  out  1  horizontal sync level

## Operation
- **Phase counter**
  - `phase` counts 0,1,2,3,0,…
  - `lfsr` advances on the edge where `phase`==3.
- **LFSR step**
  - next = {lfsr[4:0], ~(lfsr[5]^lfsr[4])}.
  - State after 0x0A (step 56, END) is forced to 0x00, giving a period of 57 states.
  - The lockup value 0x3F is never reached from 0x00.
- **Step values:**
  - 0=0x00, 1=0x01, 4=0x0F, 8=0x3B, 12=0x3C, 16=0x0E, 18=0x3A, 36=0x0D, 55=0x25, 56=0x0A.
- **Strobe decodes.** Each strobe is high only when `phase`==0 and `lfsr` equals the value below:
  - `shb`: 0x00 (step 0)
  - `shs`: 0x0F (step 4)
  - `rhs`: 0x3B (step 8)
  - `rcb`: 0x3C (step 12)
  - `rhb`: 0x0E (step 16)
  - `lrhb`: 0x3A (step 18)
  - `cnt`: 0x0D (step 36)
- All strobes are forced 0 while `reset` is high.
- **`rsync`:** on that edge, `lfsr`←0x00 and `phase`←0, overriding the normal advance. `shb` then fires on the next clk.
- **`late_blank`** (internal flag):
  - Set by `hmove_stb`; cleared by `shb`.
  - If `hmove_stb` and `shb` occur on the same clk, set wins.
- **`hblank`:**
  - Set (1) on the `shb` clk.
  - Cleared on the `rhb` clk if `late_blank`==0, otherwise on the `lrhb` clk.
  - An `hmove_stb` arriving after `rhb` has already cleared `hblank` does not re-blank the line; `late_blank` stays set until the next `shb`.
- **`hsync`:** set on the `shs` clk, cleared on the `rhs` clk.
- Level outputs change on the rising edge at the end of the clk in which the strobe is high.

## Timing
- Reset values: `lfsr`=0x00, `phase`=0, `hblank`=1, `hsync`=0, `late_blank`=0, all strobes 0.
- After `reset` falls, the first clk shows `lfsr`=0x00, `phase`=0, `shb`=1.
- Each counter state lasts 4 clks, so a line is 228 clks; each strobe fires once per line, exactly one clk wide.
- Normal line, counted in clks after `shb`:
  - `hsync` rises at +17, falls at +33 (16 clks high).
  - `hblank` falls at +65, or at +73 on an HMOVE line.
- `rsync` mid-line: the line restarts immediately. Latches are untouched except through subsequent strobes.
- Asynchronous reset mid-line returns all state to the reset values without waiting for `clk`.

## Test plan
- **Free run:** release reset and run 2×228 clks.
  - `shb` high at clk 0 and clk 228.
  - `lfsr` sequence matches the step list above.
  - 0x0A is followed by 0x00.
- **Sync/blank widths:**
  - `hsync`=1 exactly for clks 17..32.
  - `hblank`=1 for clks 0..64 and 0 for 65..227.
- **HMOVE:** `hmove_stb` at clk 10.
  - `hblank` stays 1 through clk 72 and falls at 73.
  - The next line without HMOVE falls at clk 65 again.
- **HMOVE collisions:**
  - `hmove_stb` on the same clk as `shb`: that line gets late blank.
  - `hmove_stb` at clk 100: `hblank` stays 0; the following line is normal.
- **`rsync` at clk 50:** `lfsr`=0x00 and `phase`=0 at clk 51, `shb` at clk 51, `hsync` rising at clk 68.
- **Reset mid-`hsync` (clk 20):** immediately `hsync`=0, `hblank`=1, `lfsr`=0x00. After release, the `shb` strobe fires on the first clk.

Source files
------------

// File: rtl/tia_hsync_counter.sv
// rtl/tia_hsync_counter.sv - TIA horizontal sync counter: 57-state LFSR, /4 phase, strobe decodes, hblank/hsync latches
module tia_hsync_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       rsync,
    input  logic       hmove_stb,
    output logic [5:0] lfsr,
    output logic [1:0] phase,
    output logic       shb,
    output logic       shs,
    output logic       rhs,
    output logic       rcb,
    output logic       rhb,
    output logic       lrhb,
    output logic       cnt,
    output logic       hblank,
    output logic       hsync
);

    localparam logic [5:0] LFSR_SHB  = 6'h00;
    localparam logic [5:0] LFSR_SHS  = 6'h0F;
    localparam logic [5:0] LFSR_RHS  = 6'h3B;
    localparam logic [5:0] LFSR_RCB  = 6'h3C;
    localparam logic [5:0] LFSR_RHB  = 6'h0E;
    localparam logic [5:0] LFSR_LRHB = 6'h3A;
    localparam logic [5:0] LFSR_CNT  = 6'h0D;
    // Last state of the line; the polynomial is cut short here so a line is 57 states.
    localparam logic [5:0] LFSR_END  = 6'h0A;

    logic [5:0] lfsr_q, lfsr_d;
    logic [1:0] phase_q, phase_d;
    logic       hblank_q, hblank_d;
    logic       hsync_q, hsync_d;
    logic       late_blank_q, late_blank_d;

    logic       decode_en;
    logic [5:0] lfsr_step;

    // Strobe decodes: one clk wide, only in phase 0 of the matching state, silenced by reset.
    always_comb begin
        decode_en = (phase_q == 2'd0) && !reset;
        shb  = decode_en && (lfsr_q == LFSR_SHB);
        shs  = decode_en && (lfsr_q == LFSR_SHS);
        rhs  = decode_en && (lfsr_q == LFSR_RHS);
        rcb  = decode_en && (lfsr_q == LFSR_RCB);
        rhb  = decode_en && (lfsr_q == LFSR_RHB);
        lrhb = decode_en && (lfsr_q == LFSR_LRHB);
        cnt  = decode_en && (lfsr_q == LFSR_CNT);
    end

    // Counter next state: phase always advances, LFSR steps on phase 3, RSYNC restarts the line.
    always_comb begin
        lfsr_step = (lfsr_q == LFSR_END) ? 6'h00
                                         : {lfsr_q[4:0], ~(lfsr_q[5] ^ lfsr_q[4])};
        phase_d   = phase_q + 2'd1;
        lfsr_d    = (phase_q == 2'd3) ? lfsr_step : lfsr_q;
        if (rsync) begin
            phase_d = 2'd0;
            lfsr_d  = 6'h00;
        end
    end

    // Latch next state: late_blank set beats clear, hblank release point chosen by late_blank.
    always_comb begin
        late_blank_d = late_blank_q;
        if (hmove_stb) begin
            late_blank_d = 1'b1;
        end else if (shb) begin
            late_blank_d = 1'b0;
        end

        hblank_d = hblank_q;
        if (shb) begin
            hblank_d = 1'b1;
        end else if (rhb && !late_blank_q) begin
            hblank_d = 1'b0;
        end else if (lrhb && late_blank_q) begin
            hblank_d = 1'b0;
        end

        hsync_d = hsync_q;
        if (shs) begin
            hsync_d = 1'b1;
        end else if (rhs) begin
            hsync_d = 1'b0;
        end
    end

    // State registers with asynchronous reset to the start-of-line blanked state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= 6'h00;
            phase_q      <= 2'd0;
            hblank_q     <= 1'b1;
            hsync_q      <= 1'b0;
            late_blank_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            phase_q      <= phase_d;
            hblank_q     <= hblank_d;
            hsync_q      <= hsync_d;
            late_blank_q <= late_blank_d;
        end
    end

    assign lfsr   = lfsr_q;
    assign phase  = phase_q;
    assign hblank = hblank_q;
    assign hsync  = hsync_q;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// tb/tb_tia_hsync_counter.sv - scoreboard bench for tia_hsync_counter
module tb_tia_hsync_counter;

    logic       clk;
    logic       reset;
    logic       rsync;
    logic       hmove_stb;
    logic [5:0] lfsr;
    logic [1:0] phase;
    logic       shb, shs, rhs, rcb, rhb, lrhb, cnt;
    logic       hblank, hsync;

    tia_hsync_counter dut (
        .clk       (clk),
        .reset     (reset),
        .rsync     (rsync),
        .hmove_stb (hmove_stb),
        .lfsr      (lfsr),
        .phase     (phase),
        .shb       (shb),
        .shs       (shs),
        .rhs       (rhs),
        .rcb       (rcb),
        .rhb       (rhb),
        .lrhb      (lrhb),
        .cnt       (cnt),
        .hblank    (hblank),
        .hsync     (hsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         t;
        bit         rst;
        bit         chk_lfsr;
        logic [5:0] lfsr;
        logic [1:0] phase;
        logic [6:0] strobes;
        logic       hblank;
        logic       hsync;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: position in line (clks after shb), blank level, late-blank flag.
    int   m_t    = 0;
    logic m_hb   = 1'b1;
    logic m_late = 1'b0;

    // Hand-listed LFSR values at known steps.
    function automatic bit step_value(input int step, output logic [5:0] v);
        bit known = 1'b1;
        case (step)
            0:  v = 6'h00;
            1:  v = 6'h01;
            4:  v = 6'h0F;
            8:  v = 6'h3B;
            12: v = 6'h3C;
            16: v = 6'h0E;
            18: v = 6'h3A;
            36: v = 6'h0D;
            55: v = 6'h25;
            56: v = 6'h0A;
            default: begin v = 6'h00; known = 1'b0; end
        endcase
        return known;
    endfunction

    // Drive one clk of inputs and push the expected outputs for that clk.
    task automatic drive(input logic rs, input logic hm, input logic rst_in);
        exp_t e;
        logic [5:0] v;
        @(posedge clk);
        #1;
        rsync     = rs;
        hmove_stb = hm;
        reset     = rst_in;
        e.t   = m_t;
        e.rst = rst_in;
        if (rst_in) begin
            e.chk_lfsr = 1'b1;
            e.lfsr     = 6'h00;
            e.phase    = 2'd0;
            e.strobes  = 7'b0;
            e.hblank   = 1'b1;
            e.hsync    = 1'b0;
            m_t    = 0;
            m_hb   = 1'b1;
            m_late = 1'b0;
        end else begin
            e.chk_lfsr = step_value(m_t / 4, v);
            e.lfsr     = v;
            e.phase    = 2'(m_t % 4);
            e.strobes  = {m_t == 0, m_t == 16, m_t == 32, m_t == 48,
                          m_t == 64, m_t == 72, m_t == 144};
            e.hblank   = m_hb;
            e.hsync    = (m_t >= 17) && (m_t <= 32);
            if (m_t == 0)
                m_hb = 1'b1;
            else if (m_t == 64 && !m_late)
                m_hb = 1'b0;
            else if (m_t == 72 && m_late)
                m_hb = 1'b0;
            if (hm)
                m_late = 1'b1;
            else if (m_t == 0)
                m_late = 1'b0;
            m_t = rs ? 0 : (m_t + 1) % 228;
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input int hm_t, input int rs_t);
        for (int i = 0; i < n; i++)
            drive(m_t == rs_t, m_t == hm_t, 1'b0);
    endtask

    task automatic check_field(input string nm, input int got, input int want,
                               input int tt, inout bit bad);
        if (got != want) begin
            $display("FAIL %s vec=%0d t=%0d got=%0h exp=%0h", nm, vectors, tt, got, want);
            bad = 1'b1;
        end
    endtask

    // Monitor: DUT presents a new output set every clk; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            bit bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            if (e.chk_lfsr)
                check_field("lfsr", int'(lfsr), int'(e.lfsr), e.t, bad);
            check_field("phase", int'(phase), int'(e.phase), e.t, bad);
            check_field("strobes", int'({shb, shs, rhs, rcb, rhb, lrhb, cnt}),
                        int'(e.strobes), e.t, bad);
            check_field(e.rst ? "hblank_rst" : "hblank", int'(hblank), int'(e.hblank), e.t, bad);
            check_field(e.rst ? "hsync_rst" : "hsync", int'(hsync), int'(e.hsync), e.t, bad);
            check_field("lockup", int'(lfsr == 6'h3F), 0, e.t, bad);
            vectors++;
            if (bad)
                miscompares++;
        end
    end

    initial begin
        reset     = 1'b1;
        rsync     = 1'b0;
        hmove_stb = 1'b0;

        repeat (3) drive(1'b0, 1'b0, 1'b1);
        run(456, -1, -1);
        run(228, 10, -1);
        run(228, -1, -1);
        run(228, 0, -1);
        run(228, 100, -1);
        run(228, -1, -1);
        run(51, -1, 50);
        run(228, -1, -1);
        run(20, -1, -1);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        run(228, -1, -1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
